// File: rtl/servive_uart_arb.sv
// Arbiter for the UART TX pad: the CPU GPIO owns the line by default, and a
// hardware byte transmitter gets bounded bursts once the line has been idle.
module servive_uart_arb #(
    parameter int unsigned CLKS_PER_BIT = 139,
    parameter int unsigned IDLE_BITS    = 10,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_gpio_q,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_hw_active,
    output logic       o_collision,
    input  logic       i_clr_coll,
    output logic       o_uart_txd
);

    localparam int unsigned IDLE_T  = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W  = $clog2(IDLE_T + 1);
    localparam int unsigned CLK_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        CPU_OWN = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t               state;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [3:0]           bit_cnt;
    logic [CLK_W-1:0]     clk_cnt;
    logic [BURST_W-1:0]   burst_cnt;
    logic [7:0]           data;

    logic idle_done;
    logic bit_last;
    logic stop_last;
    logic grant;
    logic chain;

    assign idle_done = (idle_cnt == IDLE_W'(IDLE_T));
    assign bit_last  = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
    assign stop_last = (bit_cnt == 4'd9) && bit_last;

    // gpio must still be high in the grant cycle, so a falling CPU edge always wins
    assign grant = (state == CPU_OWN) && idle_done && i_gpio_q && i_tx_valid;
    assign chain = (state == SEND) && stop_last && i_tx_valid
                   && (burst_cnt < BURST_W'(MAX_BURST));

    assign o_tx_ready  = grant | chain;
    assign o_hw_active = (state == SEND);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= CPU_OWN;
            idle_cnt    <= '0;
            bit_cnt     <= '0;
            clk_cnt     <= '0;
            burst_cnt   <= '0;
            data        <= '0;
            o_uart_txd  <= 1'b1;
            o_collision <= 1'b0;
        end else begin
            if ((state == SEND) && !i_gpio_q) begin
                o_collision <= 1'b1;
            end else if (i_clr_coll) begin
                o_collision <= 1'b0;
            end

            case (state)
                CPU_OWN: begin
                    o_uart_txd <= i_gpio_q;
                    if (!i_gpio_q) begin
                        idle_cnt <= '0;
                    end else if (!idle_done) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                    if (grant) begin
                        data       <= i_tx_data;
                        burst_cnt  <= BURST_W'(1);
                        bit_cnt    <= '0;
                        clk_cnt    <= '0;
                        idle_cnt   <= '0;
                        o_uart_txd <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    idle_cnt <= '0;
                    if (!bit_last) begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end else begin
                        clk_cnt <= '0;
                        // pad register is loaded with the level of the bit about to start
                        if (bit_cnt != 4'd9) begin
                            bit_cnt    <= bit_cnt + 4'd1;
                            o_uart_txd <= (bit_cnt == 4'd8) ? 1'b1 : data[bit_cnt[2:0]];
                        end else if (chain) begin
                            data       <= i_tx_data;
                            burst_cnt  <= burst_cnt + BURST_W'(1);
                            bit_cnt    <= '0;
                            o_uart_txd <= 1'b0;
                        end else begin
                            state      <= CPU_OWN;
                            burst_cnt  <= '0;
                            bit_cnt    <= '0;
                            o_uart_txd <= i_gpio_q;
                        end
                    end
                end
                default: state <= CPU_OWN;
            endcase
        end
    end

endmodule

// File: tb/tb_servive_uart_arb.sv
// Bench for servive_uart_arb: reset/passthrough vector table, then frame,
// burst, collision and mid-frame reset sequences checked against a txd queue.
module tb_servive_uart_arb;

    localparam int unsigned CPB = 4;
    localparam int unsigned IDB = 2;
    localparam int unsigned MB  = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       gpio     = 1'b0;
    logic       tx_valid = 1'b0;
    logic       clr      = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       ready;
    logic       hw;
    logic       coll;
    logic       txd;

    int n_checks = 0;
    int n_pass   = 0;
    logic exp_q[$];

    typedef struct {
        logic rst;
        logic gpio;
        logic valid;
        logic clr;
        logic txd;
        logic rdy;
        logic hw;
        logic coll;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    servive_uart_arb #(
        .CLKS_PER_BIT(CPB),
        .IDLE_BITS   (IDB),
        .MAX_BURST   (MB)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_gpio_q   (gpio),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (ready),
        .o_hw_active(hw),
        .o_collision(coll),
        .i_clr_coll (clr),
        .o_uart_txd (txd)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic r, input logic g, input logic v,
                         input logic [7:0] d, input logic c);
        @(posedge clk);
        #1;
        rst_n    = r;
        gpio     = g;
        tx_valid = v;
        tx_data  = d;
        clr      = c;
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [7:0] d);
        for (int i = 0; i < int'(CPB); i++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < int'(CPB); i++) exp_q.push_back(d[b]);
        for (int i = 0; i < int'(CPB); i++) exp_q.push_back(1'b1);
    endtask

    // One cycle: check ready against the bench's expectation, and txd/hw_active
    // against the queued frame levels; an accepted byte queues its frame.
    task automatic cyc_chk(input logic r, input logic g, input logic v,
                           input logic [7:0] d, input logic c, input logic exp_rdy);
        drive(r, g, v, d, c);
        chk("ready", ready, exp_rdy);
        chk("hw_active", hw, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("txd_frame", txd, exp_q.pop_front());
        if (exp_rdy) push_frame(d);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        // reset with gpio toggling and valid high, then passthrough 1,0,0,1
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst, vecs[i].gpio, vecs[i].valid, 8'h00, vecs[i].clr);
            chk("vec_txd", txd, vecs[i].txd);
            chk("vec_ready", ready, vecs[i].rdy);
            chk("vec_hw", hw, vecs[i].hw);
            chk("vec_coll", coll, vecs[i].coll);
        end

        // single byte 0xA5; first a tie where gpio falls as the idle time completes
        do_reset();
        for (int k = 0; k < 8; k++) cyc_chk(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        cyc_chk(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        for (int k = 0; k <= 8; k++) cyc_chk(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, k == 8);
        for (int j = 1; j <= 40; j++) cyc_chk(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        cyc_chk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("cpu_back_hi", txd, 1'b1);
        cyc_chk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("cpu_back_lo", txd, 1'b0);

        // burst of two with valid held, then forced idle before the third byte
        do_reset();
        for (int k = 0; k <= 8; k++) cyc_chk(1'b1, 1'b1, 1'b1, 8'h01, 1'b0, k == 8);
        for (int j = 1; j <= 40; j++) cyc_chk(1'b1, 1'b1, 1'b1, 8'h02, 1'b0, j == 40);
        for (int j = 1; j <= 40; j++) cyc_chk(1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        for (int k = 0; k <= 8; k++) cyc_chk(1'b1, 1'b1, 1'b1, 8'h03, 1'b0, k == 8);
        for (int j = 1; j <= 40; j++) cyc_chk(1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0);
        cyc_chk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // saturated idle counter grants at once; collisions and set-over-clear
        do_reset();
        for (int k = 0; k < 20; k++) cyc_chk(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        cyc_chk(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
        for (int j = 1; j <= 40; j++) begin
            cyc_chk(1'b1, !(j == 10 || j == 20), 1'b0, 8'h5A, (j == 15 || j == 20), 1'b0);
            if (j == 9)  chk("coll_clear", coll, 1'b0);
            if (j == 11) chk("coll_set", coll, 1'b1);
            if (j == 16) chk("coll_cleared", coll, 1'b0);
            if (j == 21) chk("coll_set_wins", coll, 1'b1);
        end
        cyc_chk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("coll_sticky", coll, 1'b1);
        cyc_chk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("coll_clr", coll, 1'b0);

        // reset during bit 3 (a zero bit), then a fresh idle period before re-grant
        do_reset();
        for (int k = 0; k <= 8; k++) cyc_chk(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, k == 8);
        for (int j = 1; j <= 13; j++) cyc_chk(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        cyc_chk(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        exp_q.delete();
        for (int k = 0; k <= 8; k++) begin
            cyc_chk(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, k == 8);
            if (k == 0) begin
                chk("rst_txd", txd, 1'b1);
                chk("rst_coll", coll, 1'b0);
            end
        end
        for (int j = 1; j <= 40; j++) cyc_chk(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        cyc_chk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
